// File: rtl/vga_write_buffer_if.sv
// CPU-side bus and VGA RAM write/read handshake bundle for the posted-write buffer.
// The slave modport is the buffer; the master modport is the CPU/VGA side that drives it.
interface vga_write_buffer_if #(
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              _vga_mem;
  logic              _wr;
  logic              _rd;
  logic              _bhe;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_data;
  logic              cpu_ready;
  logic              busy;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [1:0]        wr_be;
  logic              wr_ack;
  logic              rd_req;
  logic              rd_ack;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output _vga_mem, _wr, _rd, _bhe, cpu_addr, cpu_data, busy, wr_ack, rd_ack,
    input  cpu_ready, wr_req, wr_addr, wr_data, wr_be, rd_req, fifo_count
  );

  modport slave (
    input  _vga_mem, _wr, _rd, _bhe, cpu_addr, cpu_data, busy, wr_ack, rd_ack,
    output cpu_ready, wr_req, wr_addr, wr_data, wr_be, rd_req, fifo_count
  );
endinterface

// File: rtl/vga_write_buffer.sv
// Posted-write FIFO between the 8086 bus and VGA RAM: writes push on their start cycle, head visible next cycle.
// Backpressure: cpu_ready drops on a write into a full FIFO and while a read waits for the drain and rd_ack.
module vga_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 17
) (
  input logic               clock,
  input logic               _reset,
  vga_write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
  } entry_t;

  typedef enum logic [2:0] {IDLE, WSTALL, RDRAIN, RREQ, RDONE} state_t;

  state_t           state;
  entry_t           mem [DEPTH];
  entry_t           skid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             cpu_ready_q;
  logic             rd_req_q;
  logic             wr_sel_q;
  logic             rd_sel_q;

  logic             wr_sel;
  logic             rd_sel;
  logic             wr_start;
  logic             rd_start;
  logic             full;
  logic             wr_req_c;
  logic             pop;
  logic             push;
  logic [1:0]       be_in;
  entry_t           entry_in;
  entry_t           push_entry;

  always_comb begin
    wr_sel     = !bus._vga_mem && !bus._wr;
    rd_sel     = !bus._vga_mem && !bus._rd;
    rd_start   = rd_sel && !rd_sel_q;
    // A low _rd wins over a simultaneous write strobe.
    wr_start   = wr_sel && !wr_sel_q && bus._rd;
    be_in      = {~bus._bhe, ~bus.cpu_addr[0]};
    entry_in   = '{addr: {bus.cpu_addr[ADDR_W-1:1], 1'b0}, data: bus.cpu_data, be: be_in};
    full       = (count == CNT_W'(DEPTH));
    wr_req_c   = (count != '0) && !bus.busy;
    pop        = wr_req_c && bus.wr_ack;
    push       = 1'b0;
    push_entry = entry_in;
    if (state == IDLE && wr_start && be_in != 2'b00 && !full) begin
      push = 1'b1;
    end else if (state == WSTALL && pop) begin
      push       = 1'b1;
      push_entry = skid;
    end
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cpu_ready_q <= 1'b1;
      rd_req_q    <= 1'b0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      skid        <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_sel_q <= wr_sel;
      rd_sel_q <= rd_sel;
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);

      case (state)
        IDLE: begin
          if (rd_start) begin
            state       <= RDRAIN;
            cpu_ready_q <= 1'b0;
          end else if (wr_start && be_in != 2'b00 && full) begin
            state       <= WSTALL;
            skid        <= entry_in;
            cpu_ready_q <= 1'b0;
          end
        end
        WSTALL: begin
          if (pop) begin
            state       <= IDLE;
            cpu_ready_q <= 1'b1;
          end
        end
        RDRAIN: begin
          // Reads wait until every posted write has reached VGA RAM.
          if (count == '0 && !bus.busy) begin
            state    <= RREQ;
            rd_req_q <= 1'b1;
          end
        end
        RREQ: begin
          if (bus.rd_ack) begin
            state       <= RDONE;
            rd_req_q    <= 1'b0;
            cpu_ready_q <= 1'b1;
          end else if (bus.busy) begin
            state    <= RDRAIN;
            rd_req_q <= 1'b0;
          end
        end
        RDONE: begin
          if (bus._rd || bus._vga_mem) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ready  = cpu_ready_q;
  assign bus.rd_req     = rd_req_q;
  assign bus.wr_req     = wr_req_c;
  assign bus.wr_addr    = mem[rd_ptr].addr;
  assign bus.wr_data    = mem[rd_ptr].data;
  assign bus.wr_be      = mem[rd_ptr].be;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_vga_write_buffer.sv
// Bench for vga_write_buffer: vector table, directed corner sequences, and a queue-based random model.
`timescale 1ns/1ps
module tb_vga_write_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 17;

  logic clock  = 1'b0;
  logic _reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #10 clock = ~clock;

  vga_write_buffer_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  vga_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock  (clock),
    ._reset (_reset),
    .bus    (bus)
  );

  typedef struct {
    logic [16:0] addr;
    logic        bhe;
    logic [15:0] data;
    logic        push;
    logic [16:0] exp_addr;
    logic [1:0]  exp_be;
  } vec_t;

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } ent_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic bus_idle();
    bus._vga_mem = 1'b1;
    bus._wr      = 1'b1;
    bus._rd      = 1'b1;
  endtask

  task automatic write_pulse(input logic [16:0] a, input logic [15:0] d, input logic bhe);
    bus._vga_mem = 1'b0;
    bus._wr      = 1'b0;
    bus.cpu_addr = a;
    bus.cpu_data = d;
    bus._bhe     = bhe;
    tick();
    bus_idle();
    tick();
  endtask

  task automatic wait_rd_req(input int limit, input string nm);
    int n = 0;
    while (bus.rd_req !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk(nm, bus.rd_req, 1'b1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [6];
    logic [15:0] fill_d [5];
    ent_t        q [$];
    ent_t        skid;
    ent_t        e;
    bit          stalled;
    bit          prev_sel;
    bit          sel;
    bit          start;
    bit          pop;
    bit          full;
    bit          exp_req;
    logic [1:0]  be;

    vecs[0] = '{17'h00010, 1'b0, 16'hA55A, 1'b1, 17'h00010, 2'b11};
    vecs[1] = '{17'h00011, 1'b0, 16'h1234, 1'b1, 17'h00010, 2'b10};
    vecs[2] = '{17'h00011, 1'b1, 16'h4321, 1'b0, 17'h00000, 2'b00};
    vecs[3] = '{17'h00010, 1'b1, 16'h00FF, 1'b1, 17'h00010, 2'b01};
    vecs[4] = '{17'h1FFFF, 1'b0, 16'hBEEF, 1'b1, 17'h1FFFE, 2'b10};
    vecs[5] = '{17'h1FFFE, 1'b0, 16'hCAFE, 1'b1, 17'h1FFFE, 2'b11};
    for (int i = 0; i < 5; i++) fill_d[i] = 16'(16'hC000 + i * 257);

    bus_idle();
    bus._bhe     = 1'b1;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
    bus.busy     = 1'b0;
    bus.wr_ack   = 1'b0;
    bus.rd_ack   = 1'b0;

    // Reset state
    tick();
    chk("rst_cpu_ready", bus.cpu_ready, 1'b1);
    chk("rst_wr_req", bus.wr_req, 1'b0);
    chk("rst_rd_req", bus.rd_req, 1'b0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_wr_be", bus.wr_be, 0);
    _reset = 1'b1;
    tick();

    // Single writes from an empty FIFO
    for (int i = 0; i < 6; i++) begin
      bus.busy     = 1'b0;
      bus.wr_ack   = 1'b0;
      bus._vga_mem = 1'b0;
      bus._wr      = 1'b0;
      bus.cpu_addr = vecs[i].addr;
      bus.cpu_data = vecs[i].data;
      bus._bhe     = vecs[i].bhe;
      tick();
      chk("vec_count", bus.fifo_count, 32'(vecs[i].push));
      chk("vec_cpu_ready", bus.cpu_ready, 1'b1);
      chk("vec_wr_req", bus.wr_req, vecs[i].push);
      if (vecs[i].push) begin
        chk("vec_wr_addr", bus.wr_addr, vecs[i].exp_addr);
        chk("vec_wr_be", bus.wr_be, vecs[i].exp_be);
        chk("vec_wr_data", bus.wr_data, vecs[i].data);
      end
      bus_idle();
      bus.wr_ack = 1'b1;
      tick();
      chk("vec_drained", bus.fifo_count, 0);
      bus.wr_ack = 1'b0;
    end

    // Fill with busy held, fifth write stalls
    bus.busy = 1'b1;
    for (int i = 0; i < 4; i++) write_pulse(17'(17'h00100 + i * 2), fill_d[i], 1'b0);
    chk("fill_count", bus.fifo_count, 4);
    chk("fill_ready", bus.cpu_ready, 1'b1);
    bus._vga_mem = 1'b0;
    bus._wr      = 1'b0;
    bus.cpu_addr = 17'h00108;
    bus.cpu_data = fill_d[4];
    tick();
    chk("stall_ready", bus.cpu_ready, 1'b0);
    chk("stall_count", bus.fifo_count, 4);
    tick();
    chk("stall_hold", bus.cpu_ready, 1'b0);
    bus.busy   = 1'b0;
    bus.wr_ack = 1'b1;
    #1;
    chk("stall_wr_req", bus.wr_req, 1'b1);
    chk("stall_head0", bus.wr_data, fill_d[0]);
    tick();
    chk("unstall_ready", bus.cpu_ready, 1'b1);
    chk("unstall_count", bus.fifo_count, 4);
    bus_idle();
    for (int k = 1; k < 5; k++) begin
      chk("fill_order", bus.wr_data, fill_d[k]);
      tick();
    end
    chk("fill_drained", bus.fifo_count, 0);
    bus.wr_ack = 1'b0;

    // Read queued behind two writes
    bus.busy = 1'b1;
    write_pulse(17'h00200, 16'h0A0A, 1'b0);
    write_pulse(17'h00202, 16'h0B0B, 1'b0);
    chk("rdq_count", bus.fifo_count, 2);
    bus._vga_mem = 1'b0;
    bus._rd      = 1'b0;
    tick();
    chk("rdq_ready_low", bus.cpu_ready, 1'b0);
    chk("rdq_no_req", bus.rd_req, 1'b0);
    tick();
    chk("rdq_no_req_busy", bus.rd_req, 1'b0);
    bus.busy   = 1'b0;
    bus.wr_ack = 1'b1;
    wait_rd_req(10, "rdq_rd_req");
    chk("rdq_after_drain", bus.fifo_count, 0);
    chk("rdq_ready_in_req", bus.cpu_ready, 1'b0);
    bus.wr_ack = 1'b0;
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    chk("rdq_ready_ack", bus.cpu_ready, 1'b1);
    chk("rdq_req_drop", bus.rd_req, 1'b0);
    tick();
    chk("rdq_done_hold", bus.cpu_ready, 1'b1);
    bus_idle();
    tick();
    bus.busy = 1'b1;
    write_pulse(17'h00300, 16'h3333, 1'b0);
    chk("rdq_back_idle", bus.fifo_count, 1);
    bus.busy   = 1'b0;
    bus.wr_ack = 1'b1;
    tick();
    chk("rdq_idle_drain", bus.fifo_count, 0);
    bus.wr_ack = 1'b0;

    // Illegal _wr+_rd start, then busy during the read request
    bus._vga_mem = 1'b0;
    bus._wr      = 1'b0;
    bus._rd      = 1'b0;
    bus._bhe     = 1'b0;
    tick();
    chk("illegal_no_push", bus.fifo_count, 0);
    chk("illegal_is_read", bus.cpu_ready, 1'b0);
    wait_rd_req(5, "brq_rd_req");
    bus.busy = 1'b1;
    tick();
    chk("brq_drop", bus.rd_req, 1'b0);
    tick();
    chk("brq_stay_low", bus.rd_req, 1'b0);
    bus.busy = 1'b0;
    tick();
    chk("brq_reassert", bus.rd_req, 1'b1);
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    chk("brq_ready", bus.cpu_ready, 1'b1);
    bus_idle();
    tick();

    // Reset in the middle of a drain
    bus.busy = 1'b1;
    for (int i = 0; i < 4; i++) write_pulse(17'(17'h00400 + i * 2), 16'(16'h5000 + i), 1'b0);
    bus.busy   = 1'b0;
    bus.wr_ack = 1'b1;
    tick();
    chk("mid_count", bus.fifo_count, 3);
    #3;
    _reset = 1'b0;
    #1;
    chk("arst_wr_req", bus.wr_req, 1'b0);
    chk("arst_count", bus.fifo_count, 0);
    chk("arst_ready", bus.cpu_ready, 1'b1);
    tick();
    _reset = 1'b1;
    tick();
    tick();
    chk("post_rst_count", bus.fifo_count, 0);
    chk("post_rst_wr_req", bus.wr_req, 1'b0);
    bus.wr_ack = 1'b0;
    tick();

    // Random writes against a queue model of the posted-write buffer
    stalled  = 1'b0;
    prev_sel = 1'b0;
    skid     = '0;
    for (int c = 0; c < 400; c++) begin
      bus.busy   = ($urandom_range(0, 9) < 5);
      bus.wr_ack = ($urandom_range(0, 9) < 6);
      if (!stalled) begin
        if ($urandom_range(0, 2) == 0) begin
          bus._vga_mem = 1'b0;
          bus._wr      = 1'b0;
          bus.cpu_addr = 17'($urandom);
          bus.cpu_data = 16'($urandom);
          bus._bhe     = 1'($urandom_range(0, 1));
        end else begin
          bus._vga_mem = 1'($urandom_range(0, 1));
          bus._wr      = 1'b1;
        end
      end
      #1;
      exp_req = (q.size() != 0) && !bus.busy;
      chk("rnd_count", bus.fifo_count, q.size());
      chk("rnd_ready", bus.cpu_ready, !stalled);
      chk("rnd_wr_req", bus.wr_req, exp_req);
      if (q.size() != 0) begin
        chk("rnd_addr", bus.wr_addr, q[0].addr);
        chk("rnd_data", bus.wr_data, q[0].data);
        chk("rnd_be", bus.wr_be, q[0].be);
      end
      sel      = !bus._vga_mem && !bus._wr;
      start    = sel && !prev_sel;
      prev_sel = sel;
      pop      = exp_req && bus.wr_ack;
      be       = {~bus._bhe, ~bus.cpu_addr[0]};
      if (stalled) begin
        if (pop) begin
          void'(q.pop_front());
          q.push_back(skid);
          stalled = 1'b0;
        end
      end else begin
        full = (q.size() == DEPTH);
        if (pop) void'(q.pop_front());
        if (start && be != 2'b00) begin
          e = '{addr: {bus.cpu_addr[16:1], 1'b0}, data: bus.cpu_data, be: be};
          if (full) begin
            stalled = 1'b1;
            skid    = e;
          end else begin
            q.push_back(e);
          end
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
